wrap_counter: RTL and testbench
===============================

// Module: wrap_counter
// PURPOSE
//  Parameterised synchronous up-counter that cycles MIN..MAX inclusive and wraps to MIN.
//  Supports parallel load and count enable.
//  Used as a clock-cycle divider/timebase, e.g. WIDTH=28, MIN=0, MAX=99_999_999 yields
//  one 1 s period per 100 M cycles at 100 MHz; consumers decode q values.
//  Parameters are positional in this order: WIDTH, MIN, MAX.
// PARAMETERS
//  WIDTH  28           bit width of q and d
//  MIN    0            reset value and wrap target (must be <= MAX, < 2**WIDTH)
//  MAX    99_999_999   terminal value; q==MAX with ce=1 wraps to MIN next cycle
// PORTS
//  clk   in   1      rising-edge clock
//  rstn  in   1      reset, asynchronous, active-low
//  pe    in   1      parallel load enable (priority over ce)
//  ce    in   1      count enable
//  d     in   WIDTH  load data; narrower connections zero-extend per Verilog rules
//  q     out  WIDTH  current count, registered
//  tc    out  1      terminal count: combinational (q==MAX) && ce && !pe; may be left unconnected
// BEHAVIOUR
//  - Reset (rstn=0, asynchronous):
//    - q <= MIN immediately, independent of clk.
//    - q holds MIN while rstn=0.
//    - First count occurs on the first rising edge after rstn rises.
//  - Per rising clk edge, evaluated in priority order:
//    1. pe=1: q <= d, loaded verbatim (no clamping), 1-cycle latency.
//    2. ce=1 and q>=MAX: q <= MIN (wrap). Covers an out-of-range load above MAX.
//    3. ce=1 and q<MAX: q <= q+1.
//    4. otherwise: q holds.
//  - Loaded values below MIN count upward normally until MAX, then wrap.
//  - Period with ce tied high: MAX-MIN+1 cycles. Each value appears exactly once per period.
//  - Arithmetic:
//    - Unsigned, modulo 2**WIDTH internally.
//    - The compare q>=MAX prevents passing MAX, so no overflow occurs when MAX < 2**WIDTH-1.
//    - MAX = 2**WIDTH-1 is legal and wraps to MIN.
//  - MIN==MAX is legal: q stays at MIN, and tc=1 whenever ce=1.
//  - pe and ce both 1: load wins, no increment applied to d that cycle.
//  - Reset asserted mid-count: q returns to MIN asynchronously, and the count restarts from MIN.
//  - No internal state other than q; q is the only register.
//  - Fully synchronous to clk apart from the reset.
// TESTING
//  T1 reset: WIDTH=4,MIN=0,MAX=9; hold rstn=0 -> q=0 with no clk edge required;
//     release, ce=1 -> q=1,2,... on successive edges.
//  T2 wrap: MIN=0,MAX=9, ce=1 for 12 edges from reset -> q=1..9,0,1,2;
//     tc=1 only during the cycle q=9.
//  T3 nonzero MIN: WIDTH=4,MIN=3,MAX=6, ce=1 -> q=3,4,5,6,3,4...; period 4 cycles.
//  T4 load/priority: MAX=9, q=2, pe=1,ce=1,d=7 -> q=7 next edge;
//     then pe=0 -> 8,9,0; load d=12 (>MAX), ce=1 -> next q=MIN=0.
//  T5 enable/async reset: ce=0 at q=5 for 3 edges -> q stays 5;
//     pulse rstn low between edges at q=5 -> q=0 immediately, resumes 1,2...
//  T6 divider: defaults (28,0,99_999_999), ce=1, pe=0, d=0 -> q==99_999_998 exactly once
//     per 100_000_000 cycles; q=0 at cycle 100_000_000 after reset.

Source files
------------

// File: rtl/wrap_counter.sv
// Modulo up-counter cycling MIN..MAX with parallel load and count enable.
// Acts as a timebase; tc flags the cycle that will wrap back to MIN.
module wrap_counter #(
    parameter int unsigned      WIDTH = 28,
    parameter logic [WIDTH-1:0] MIN   = WIDTH'(0),
    parameter logic [WIDTH-1:0] MAX   = WIDTH'(99_999_999)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             pe,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // >= rather than == so an out-of-range load above MAX still wraps
    always_comb begin
        q_d = q_q;
        if (pe) begin
            q_d = d;
        end else if (ce) begin
            if (q_q >= MAX) begin
                q_d = MIN;
            end else begin
                q_d = q_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q_q <= MIN;
        end else begin
            q_q <= q_d;
        end
    end

    assign q  = q_q;
    assign tc = (q_q == MAX) && ce && !pe;

endmodule

// File: tb/tb_wrap_counter.sv
// Directed bench for wrap_counter: small instances cover wrap, nonzero MIN,
// full-range MAX, MIN==MAX, load priority, enable hold and async reset.
module tb_wrap_counter;

    logic       clk = 1'b0;
    logic       rstn;
    logic       pe_a, ce_a;
    logic [3:0] d_a;
    logic       ce_b;
    logic [3:0] q_a, q_b, q_c, q_d;
    logic       tc_a, tc_b, tc_c, tc_d;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wrap_counter #(4, 4'd0, 4'd9) dut_a (
        .clk(clk), .rstn(rstn), .pe(pe_a), .ce(ce_a),
        .d(d_a), .q(q_a), .tc(tc_a)
    );

    wrap_counter #(4, 4'd3, 4'd6) dut_b (
        .clk(clk), .rstn(rstn), .pe(1'b0), .ce(ce_b),
        .d(4'd0), .q(q_b), .tc(tc_b)
    );

    wrap_counter #(4, 4'd0, 4'd15) dut_c (
        .clk(clk), .rstn(rstn), .pe(1'b0), .ce(ce_b),
        .d(4'd0), .q(q_c), .tc(tc_c)
    );

    wrap_counter #(4, 4'd5, 4'd5) dut_d (
        .clk(clk), .rstn(rstn), .pe(1'b0), .ce(ce_b),
        .d(4'd0), .q(q_d), .tc(tc_d)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] nxt(input logic [3:0] e,
                                       input logic [3:0] mn,
                                       input logic [3:0] mx);
        return (e >= mx) ? mn : e + 4'd1;
    endfunction

    logic [3:0] ea, eb, ec;

    initial begin
        rstn = 1'b1;
        pe_a = 1'b0;
        ce_a = 1'b0;
        d_a  = 4'd0;
        ce_b = 1'b0;
        #1 rstn = 1'b0;
        #1;
        chk("rst_a", 32'(q_a), 0);
        chk("rst_b", 32'(q_b), 3);
        chk("rst_c", 32'(q_c), 0);
        chk("rst_d", 32'(q_d), 5);

        ce_a = 1'b1;
        ce_b = 1'b1;
        tick();
        tick();
        chk("rst_hold_a", 32'(q_a), 0);
        chk("rst_hold_b", 32'(q_b), 3);

        rstn = 1'b1;
        ea = 4'd0;
        eb = 4'd3;
        ec = 4'd0;
        for (int i = 0; i < 22; i++) begin
            #1;
            chk("tc_a", 32'(tc_a), 32'(ea == 4'd9));
            chk("tc_b", 32'(tc_b), 32'(eb == 4'd6));
            chk("tc_c", 32'(tc_c), 32'(ec == 4'd15));
            chk("tc_d", 32'(tc_d), 1);
            tick();
            ea = nxt(ea, 4'd0, 4'd9);
            eb = nxt(eb, 4'd3, 4'd6);
            ec = nxt(ec, 4'd0, 4'd15);
            chk("cnt_a", 32'(q_a), 32'(ea));
            chk("cnt_b", 32'(q_b), 32'(eb));
            chk("cnt_c", 32'(q_c), 32'(ec));
            chk("cnt_d", 32'(q_d), 5);
        end
        chk("a_at_2", 32'(q_a), 2);

        ce_b = 1'b0;
        pe_a = 1'b1;
        d_a  = 4'd7;
        #1 chk("tc_pe_a", 32'(tc_a), 0);
        tick();
        chk("load_7", 32'(q_a), 7);
        pe_a = 1'b0;
        tick();
        chk("after_load_8", 32'(q_a), 8);
        tick();
        chk("after_load_9", 32'(q_a), 9);
        chk("tc_at_9", 32'(tc_a), 1);
        pe_a = 1'b1;
        d_a  = 4'd3;
        #1 chk("tc_masked_pe", 32'(tc_a), 0);
        pe_a = 1'b0;
        #1;
        tick();
        chk("wrap_0", 32'(q_a), 0);

        pe_a = 1'b1;
        d_a  = 4'd12;
        tick();
        chk("load_12", 32'(q_a), 12);
        pe_a = 1'b0;
        #1 chk("tc_above_max", 32'(tc_a), 0);
        tick();
        chk("wrap_above_max", 32'(q_a), 0);
        chk("hold_b", 32'(q_b), 32'(eb));
        chk("hold_c", 32'(q_c), 32'(ec));

        ce_a = 1'b0;
        pe_a = 1'b1;
        d_a  = 4'd4;
        tick();
        chk("load_ce0", 32'(q_a), 4);
        pe_a = 1'b0;
        ce_a = 1'b1;
        tick();
        chk("cnt_5", 32'(q_a), 5);
        ce_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("tc_ce0", 32'(tc_a), 0);
            tick();
            chk("ce0_hold", 32'(q_a), 5);
        end

        #2 rstn = 1'b0;
        #1;
        chk("async_rst_a", 32'(q_a), 0);
        chk("async_rst_b", 32'(q_b), 3);
        chk("async_rst_c", 32'(q_c), 0);
        rstn = 1'b1;
        ce_a = 1'b1;
        #1 chk("post_rst_a", 32'(q_a), 0);
        tick();
        chk("resume_1", 32'(q_a), 1);
        tick();
        chk("resume_2", 32'(q_a), 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
